// File: rtl/fp_pkg.sv
// Shared types and constants for the pipelined IEEE-754 adder/subtractor.
// Default field widths, flag bit positions, qNaN builder, unpacked operand.
package fp_pkg;

    localparam int EXP_W_D = 8;
    localparam int MAN_W_D = 23;

    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UDF = 1;
    localparam int FLG_INX = 0;

    // Sized by the package defaults; the adder's parameters follow them.
    typedef struct packed {
        logic               sign;
        logic [EXP_W_D-1:0] exp;
        logic [MAN_W_D:0]   sig;
        logic               is_zero;
        logic               is_inf;
        logic               is_nan;
        logic               is_snan;
    } fp_unp_t;

    // Canonical quiet NaN {0, all-ones, 1, zeros}, right-aligned.
    function automatic logic [63:0] qnan_bits(input int ew, input int mw);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < ew; i++) v[mw+i] = 1'b1;
        v[mw-1] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Leading-zero counter: number of zeros above the most significant one.
// Ports: data_i (WIDTH bits), cnt_o (WIDTH when data_i is all zero).
module fp_lzc #(
    parameter int  WIDTH = 27,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    cnt_o
);

    // Ascending scan: the last (highest) set bit wins.
    always_comb begin
        cnt_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) cnt_o = CW'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point add/subtract, RNE rounding, DAZ/FTZ.
// Ports: clk, rst_n, in_valid/in_ready, a, b, op, out_valid/out_ready, result, flags.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int  EXP_W = EXP_W_D,
    parameter int  MAN_W = MAN_W_D,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int SW = MAN_W + 4;
    localparam int DW = $clog2(SW + 1);
    localparam int LW = $clog2(SW + 1);
    localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EXP_W:0] E1 = (EXP_W + 1)'(1);

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic             sub;
        logic [SW-1:0]    xs;
        logic [SW-1:0]    ys;
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flg;
    } s1_t;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [SW:0]      sum;
        logic             spec;
        logic [W-1:0]     spec_res;
        logic [3:0]       spec_flg;
    } s2_t;

    function automatic fp_unp_t unpack(input logic [W-1:0] v);
        fp_unp_t          u;
        logic [EXP_W-1:0] e;
        logic [MAN_W-1:0] m;
        e         = v[W-2 -: EXP_W];
        m         = v[MAN_W-1:0];
        u.sign    = v[W-1];
        u.is_zero = (e == '0);
        u.is_inf  = (&e) && (m == '0);
        u.is_nan  = (&e) && (m != '0);
        u.is_snan = u.is_nan && !m[MAN_W-1];
        u.exp     = u.is_zero ? '0 : e;
        u.sig     = u.is_zero ? '0 : {1'b1, m};
        return u;
    endfunction

    logic en;
    logic v1_q, v2_q, out_valid_q;
    logic [W-1:0] result_q, result_d;
    logic [3:0] flags_q, flags_d;
    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;

    // S1: unpack, order by magnitude, align the smaller operand
    fp_unp_t ua, ub;
    logic swap;
    logic [EXP_W-1:0] ye, dexp;
    logic [MAN_W:0] ysig;
    logic [DW-1:0] dcl;
    logic [SW-1:0] yfull, ysh, mask;
    logic lost;

    always_comb begin
        ua      = unpack(a);
        ub      = unpack(b);
        ub.sign = b[W-1] ^ op;
        swap    = {ub.exp, ub.sig} > {ua.exp, ua.sig};

        s1_d      = '0;
        s1_d.sign = swap ? ub.sign : ua.sign;
        s1_d.exp  = swap ? ub.exp : ua.exp;
        s1_d.sub  = ua.sign ^ ub.sign;
        s1_d.xs   = {(swap ? ub.sig : ua.sig), 3'b000};
        ye        = swap ? ua.exp : ub.exp;
        ysig      = swap ? ua.sig : ub.sig;

        dexp = s1_d.exp - ye;
        if (32'(dexp) >= 32'(SW)) dcl = DW'(SW);
        else dcl = DW'(dexp);

        // Shifted-out bits collapse into the sticky position.
        yfull   = {ysig, 3'b000};
        mask    = (SW'(1) << dcl) - SW'(1);
        lost    = |(yfull & mask);
        ysh     = yfull >> dcl;
        s1_d.ys = {ysh[SW-1:1], ysh[0] | lost};

        s1_d.spec = ua.is_nan | ub.is_nan | ua.is_inf | ub.is_inf
                  | (ua.is_zero & ub.is_zero);
        if (ua.is_nan || ub.is_nan) begin
            s1_d.spec_res          = QNAN;
            s1_d.spec_flg[FLG_INV] = ua.is_snan | ub.is_snan;
        end else if (ua.is_inf && ub.is_inf && (ua.sign != ub.sign)) begin
            s1_d.spec_res          = QNAN;
            s1_d.spec_flg[FLG_INV] = 1'b1;
        end else if (ua.is_inf || ub.is_inf) begin
            s1_d.spec_res = {(ua.is_inf ? ua.sign : ub.sign), EMAX, MAN_W'(0)};
        end else begin
            // Only (-0)+(-0) keeps a negative zero.
            s1_d.spec_res = {ua.sign & ub.sign, (W - 1)'(0)};
        end
    end

    // S2: magnitude add or subtract; X >= Y so no negative result
    always_comb begin
        s2_d          = '0;
        s2_d.sign     = s1_q.sign;
        s2_d.exp      = s1_q.exp;
        s2_d.spec     = s1_q.spec;
        s2_d.spec_res = s1_q.spec_res;
        s2_d.spec_flg = s1_q.spec_flg;
        if (s1_q.sub) s2_d.sum = {1'b0, s1_q.xs} - {1'b0, s1_q.ys};
        else s2_d.sum = {1'b0, s1_q.xs} + {1'b0, s1_q.ys};
    end

    // S3: normalise, round to nearest even, pack
    logic [LW-1:0] lz;
    logic [EXP_W:0] lzx, emx, sh, e, e2;
    logic [SW-1:0] m;
    logic [MAN_W+1:0] mr;
    logic up, inx;

    fp_lzc #(.WIDTH(SW)) u_lzc (
        .data_i(s2_q.sum[SW-1:0]),
        .cnt_o (lz)
    );

    always_comb begin
        lzx = (EXP_W + 1)'(lz);
        emx = {1'b0, s2_q.exp} - E1;
        // Never shift below exponent 1; what remains is subnormal.
        sh  = (lzx < emx) ? lzx : emx;
        if (s2_q.sum[SW]) begin
            m = {s2_q.sum[SW:2], |s2_q.sum[1:0]};
            e = {1'b0, s2_q.exp} + E1;
        end else begin
            m = s2_q.sum[SW-1:0] << sh;
            e = {1'b0, s2_q.exp} - sh;
        end
        up  = m[2] & (m[1] | m[0] | m[3]);
        mr  = {1'b0, m[SW-1:3]} + (MAN_W + 2)'(up);
        e2  = mr[MAN_W+1] ? e + E1 : e;
        inx = |m[2:0];

        result_d = '0;
        flags_d  = '0;
        if (s2_q.spec) begin
            result_d = s2_q.spec_res;
            flags_d  = s2_q.spec_flg;
        end else if (s2_q.sum == '0) begin
            result_d = '0;
        end else if (!(mr[MAN_W+1] | mr[MAN_W])) begin
            result_d         = {s2_q.sign, (W - 1)'(0)};
            flags_d[FLG_UDF] = 1'b1;
            flags_d[FLG_INX] = 1'b1;
        end else if (e2 >= {1'b0, EMAX}) begin
            result_d         = {s2_q.sign, EMAX, MAN_W'(0)};
            flags_d[FLG_OVF] = 1'b1;
            flags_d[FLG_INX] = 1'b1;
        end else begin
            result_d         = {s2_q.sign, e2[EXP_W-1:0], mr[MAN_W-1:0]};
            flags_d[FLG_INX] = inx;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else if (en) begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

endmodule

// File: doc/fp_addsub_pipe.md
FP_ADDSUB_PIPE -- requirements
Module: fp_addsub_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, stored mantissa field width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands and op valid.
REQ-006 SHALL have port in_ready  output  1  block accepts an operation this cycle.
REQ-007 SHALL have port a  input  W  operand A, IEEE-754 layout {sign, exp, man}.
REQ-008 SHALL have port b  input  W  operand B, same layout.
REQ-009 SHALL have port op  input  1  0 = A+B, 1 = A-B (B sign inverted).
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  W  rounded sum.
REQ-013 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result.

Function
REQ-014 SHALL be a 3-stage pipeline: S1 unpack/swap/align, S2 add/subtract, S3 normalise/round/pack; latency exactly 3 cycles with out_ready held high.
REQ-015 SHALL transfer on in_valid&in_ready and on out_valid&out_ready; whole pipe advances only when enable = !out_valid | out_ready; in_ready = enable.
REQ-016 SHALL hold result, flags and out_valid stable while out_valid & !out_ready; bubbles SHALL propagate and be squeezed out when enable is high.
REQ-017 SHALL sustain one operation per cycle when out_ready stays high.
REQ-018 SHALL order operands by magnitude {exp, man}; larger becomes X; result sign before special cases = sign of X.
REQ-019 SHALL right-shift the smaller significand by exponent difference, keeping guard, round and sticky (OR of all shifted-out bits); shifts >= MAN_W+3 leave only sticky.
REQ-020 SHALL add on equal effective signs, subtract on opposite signs, with a MAN_W+4-bit datapath plus carry.
REQ-021 SHALL on carry out shift right one (OR lost bit into sticky) and increment exponent.
REQ-022 SHALL on leading zeros count them (LZC) and left-shift by min(count, exp-1), decrementing exponent accordingly; this is the normalisation the earlier adder lacked.
REQ-023 SHALL round to nearest, ties to even; mantissa overflow from rounding SHALL increment exponent.
REQ-024 SHALL treat subnormal inputs as zero (DAZ) and flush subnormal results to signed zero with underflow=1, inexact=1.
REQ-025 SHALL return +0 for exact cancellation (x - x), -0 only for (-0)+(-0).
REQ-026 SHALL on exponent reaching all-ones return signed infinity with overflow=1, inexact=1.
REQ-027 SHALL propagate infinity for inf+finite; inf-inf (effective) SHALL return canonical qNaN {0, all-ones, 1, zeros} with invalid=1.
REQ-028 SHALL return canonical qNaN for any NaN input; invalid=1 only if an input is signalling NaN.
REQ-029 SHALL set inexact=1 whenever guard|round|sticky nonzero after normalisation.

Reset
REQ-030 SHALL on rst_n low immediately clear all stage valid bits, out_valid=0, result=0, flags=0; in_ready=1 after release.
REQ-031 SHALL discard in-flight operations on reset mid-operation; no result emitted for them.
REQ-032 SHALL reset only control/valid and output registers; datapath stage registers need no reset.

Structure
REQ-033 SHALL place default widths, qNaN constant builder, flag bit indices and unpacked-operand struct (sign, exp, sig, is_zero, is_inf, is_nan, is_snan) in package fp_pkg.
REQ-034 SHALL implement leading-zero count as sub-module fp_lzc, parametrised by input width.

Verification
REQ-035 1.0+1.0 (0x3F800000, 0x3F800000, op=0) -> 0x40000000, flags 0, out_valid exactly 3 cycles after accept.
REQ-036 1.5-1.25 (0x3FC00000, 0x3FA00000, op=1) -> 0x3E800000 (left-normalise by 2); 0x3F800000-0x3F800000 -> 0x00000000.
REQ-037 Ties: 0x3F800000+0x33800000 -> 0x3F800000 inexact; 0x3F800001+0x33800000 -> 0x3F800002 inexact.
REQ-038 0x7F7FFFFF+0x7F7FFFFF -> 0x7F800000 overflow|inexact; 0x7F800000+0xFF800000 -> 0x7FC00000 invalid.
REQ-039 Back-to-back 10 ops with out_ready low for cycles 4-7 -> no loss/duplication, in_ready low while stalled, results in order.
REQ-040 rst_n pulsed low with 3 ops in flight -> out_valid low immediately, no stale results after release, next op correct.
